// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM + ALU decoder sequencing a multicycle RV32I-subset datapath
// over a single req/ready memory port; outputs are forced low while reset is asserted.
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Retire,
  output logic       Illegal
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  state_t r_state, w_next;
  logic w_rdy, w_memreq, w_memwrite, w_adr, w_ir, w_pc, w_rw, w_ret, w_ill;
  logic [1:0] w_res, w_a, w_b, w_aluop, w_imm;
  logic [2:0] w_alu_dec, w_aluctl;
  assign w_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_memreq = 1'b0;
    w_memwrite = 1'b0;
    w_adr = 1'b0;
    w_ir = 1'b0;
    w_pc = 1'b0;
    w_rw = 1'b0;
    w_ret = 1'b0;
    w_ill = 1'b0;
    w_res = 2'b00;
    w_a = 2'b00;
    w_b = 2'b00;
    w_aluop = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memreq = 1'b1;
        w_b = 2'b10;
        w_res = 2'b10;
        w_ir = w_rdy;
        w_pc = w_rdy;
        w_next = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_a = 2'b01;
        w_b = 2'b01;
        w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                 op == OP_R ? S_EXECUTER :
                 op == OP_I ? S_EXECUTEI :
                 (op == OP_B && funct3 == 3'b000) ? S_BEQ :
                 op == OP_J ? S_JAL : S_ILLEGAL;
      end
      S_MEMADR: begin
        w_a = 2'b10;
        w_b = 2'b01;
        w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_memreq = 1'b1;
        w_adr = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_res = 2'b01;
        w_rw = 1'b1;
        w_ret = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_memreq = 1'b1;
        w_memwrite = 1'b1;
        w_adr = 1'b1;
        w_ret = w_rdy;
        w_next = w_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        w_a = 2'b10;
        w_aluop = 2'b10;
        w_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_a = 2'b10;
        w_b = 2'b01;
        w_aluop = 2'b10;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw = 1'b1;
        w_ret = 1'b1;
        w_next = S_FETCH;
      end
      S_BEQ: begin
        w_a = 2'b10;
        w_aluop = 2'b01;
        w_pc = Zero;
        w_ret = 1'b1;
        w_next = S_FETCH;
      end
      S_JAL: begin
        w_a = 2'b01;
        w_b = 2'b10;
        w_pc = 1'b1;
        w_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        w_ill = 1'b1;
        w_next = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // sub only for R-type (op[5]); I-type funct7b5 is part of the immediate
  assign w_alu_dec = funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                     funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign w_aluctl = w_aluop == 2'b01 ? 3'b001 : w_aluop == 2'b10 ? w_alu_dec : 3'b000;
  assign w_imm = op == OP_SW ? 2'b01 : op == OP_B ? 2'b10 : op == OP_J ? 2'b11 : 2'b00;
  // gating with reset keeps strobes low the instant reset asserts
  assign MemReq     = reset & w_memreq;
  assign MemWrite   = reset & w_memwrite;
  assign AdrSrc     = reset & w_adr;
  assign IRWrite    = reset & w_ir;
  assign PCWrite    = reset & w_pc;
  assign RegWrite   = reset & w_rw;
  assign Retire     = reset & w_ret;
  assign Illegal    = reset & w_ill;
  assign ResultSrc  = {2{reset}} & w_res;
  assign ALUSrcA    = {2{reset}} & w_a;
  assign ALUSrcB    = {2{reset}} & w_b;
  assign ImmSrc     = {2{reset}} & w_imm;
  assign ALUControl = {3{reset}} & w_aluctl;
endmodule
